// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data-memory handshake,
// stalls the pipeline while an access is in flight and formats load results.
module lsu_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_read_m_i,
  input  logic            mem_write_m_i,
  input  logic [2:0]      funct3_m_i,
  input  logic [XLEN-1:0] addr_m_i,
  input  logic [XLEN-1:0] store_data_m_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] load_data_m_o,
  output logic            stall_m_o,
  output logic            misaligned_load_o,
  output logic            misaligned_store_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] load_q, load_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;

  logic op, is_store, size_b, size_h, size_w, misaligned;

  function automatic logic [XLEN-1:0] fmt_store(input logic [1:0] sz, input logic [XLEN-1:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Lane select by byte offset, then sign/zero extension per funct3.
  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    op         = mem_read_m_i | mem_write_m_i;
    is_store   = mem_write_m_i;
    size_b     = (funct3_m_i[1:0] == 2'b00);
    size_h     = (funct3_m_i[1:0] == 2'b01);
    size_w     = ~size_b & ~size_h;
    misaligned = (size_h & addr_m_i[0]) | (size_w & (addr_m_i[1:0] != 2'b00));
  end

  assign misaligned_load_o  = mem_read_m_i & ~mem_write_m_i & misaligned;
  assign misaligned_store_o = mem_write_m_i & misaligned;
  assign stall_m_o          = op & ~misaligned & (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    load_d  = load_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (op && !misaligned) begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {addr_m_i[XLEN-1:2], 2'b00};
          wdata_d = fmt_store(funct3_m_i[1:0], store_data_m_i);
          be_d    = byte_en(funct3_m_i[1:0], addr_m_i[1:0]);
          f3_d    = funct3_m_i;
          off_d   = addr_m_i[1:0];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      // Data only counts from the cycle after the grant, which is guaranteed by WAIT.
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          load_d  = fmt_load(f3_q, off_q, dmem_rdata_i);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      load_q  <= load_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign dmem_req_o    = req_q;
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign dmem_be_o     = be_q;
  assign load_data_m_o = load_q;

endmodule
